// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship break scheduler and its random sources.
// Contains state encodings, subsystem indices and the LFSR step function.
package nexys_starship_pkg;

    typedef enum logic [3:0] {
        BG_INIT = 4'b0001,
        BG_WAIT = 4'b0010,
        BG_PICK = 4'b0100,
        BG_FIRE = 4'b1000
    } bg_state_t;

    localparam int SUB_BR = 0;
    localparam int SUB_BL = 1;
    localparam int SUB_TR = 2;
    localparam int SUB_TL = 3;

    // Taps 16,14,13,11 mapped onto bit indices 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances one step every clock outside reset.
// A zero seed would lock up the register, so it is replaced by 16'h0001.
module nexys_starship_lfsr16
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] state
);

    localparam logic [15:0] INIT_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= INIT_VAL;
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/nexys_starship_break_gen.sv
// Break scheduler: counts timer ticks, picks a healthy subsystem and pulses break_req.
// break_req is high in the second cycle after the cycle carrying the expiring tick.
module nexys_starship_break_gen
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [7:0]  BASE_INTERVAL = 8'd40,
    parameter logic [3:0]  JITTER_MASK   = 4'hF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       timer_tick,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic [1:0] level,
    input  logic [3:0] broken,
    output logic [3:0] break_req,
    output logic [3:0] random_hex,
    output logic [7:0] break_count,
    output logic       q_BG_Init,
    output logic       q_BG_Wait,
    output logic       q_BG_Pick,
    output logic       q_BG_Fire
);

    bg_state_t   state;
    logic [15:0] lfsr;
    logic [8:0]  cnt;
    logic [8:0]  load_raw;
    logic [8:0]  load_val;
    logic [3:0]  hex_val;
    logic        found;
    logic [1:0]  pick_idx;
    logic [1:0]  probe;
    logic        lfsr_unused;

    nexys_starship_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .state (lfsr)
    );

    assign load_raw    = ({1'b0, BASE_INTERVAL} >> level) + {5'b0, lfsr[11:8] & JITTER_MASK};
    assign load_val    = (load_raw == 9'd0) ? 9'd1 : load_raw;
    assign hex_val     = (lfsr[7:4] == 4'h0) ? 4'hF : lfsr[7:4];
    assign lfsr_unused = ^{lfsr[15:12], lfsr[3:2]};

    always_comb begin
        found    = 1'b0;
        pick_idx = lfsr[1:0];
        probe    = lfsr[1:0];
        // Scan furthest-first so the nearest healthy slot after the start index wins.
        for (int k = 3; k >= 0; k--) begin
            probe = lfsr[1:0] + 2'(k);
            if (!broken[probe]) begin
                found    = 1'b1;
                pick_idx = probe;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= BG_INIT;
            break_req   <= 4'b0000;
            random_hex  <= 4'h1;
            break_count <= 8'd0;
            cnt         <= 9'd0;
        end else if (gameover_ctrl) begin
            state       <= BG_INIT;
            break_req   <= 4'b0000;
            break_count <= 8'd0;
        end else begin
            break_req <= 4'b0000;
            case (state)
                BG_INIT: begin
                    break_count <= 8'd0;
                    if (play_flag) begin
                        cnt   <= load_val;
                        state <= BG_WAIT;
                    end
                end
                BG_WAIT: begin
                    if (timer_tick) begin
                        if (cnt != 9'd0) begin
                            cnt <= cnt - 9'd1;
                        end
                        if (cnt == 9'd1) begin
                            state <= BG_PICK;
                        end
                    end
                end
                BG_PICK: begin
                    // The pulse, combo and count all land together so consumers see a consistent break.
                    if (found) begin
                        break_req  <= 4'b0001 << pick_idx;
                        random_hex <= hex_val;
                        if (break_count != 8'hFF) begin
                            break_count <= break_count + 8'd1;
                        end
                        state <= BG_FIRE;
                    end else begin
                        cnt   <= load_val;
                        state <= BG_WAIT;
                    end
                end
                BG_FIRE: begin
                    cnt   <= load_val;
                    state <= BG_WAIT;
                end
                default: begin
                    state <= BG_INIT;
                end
            endcase
        end
    end

    assign q_BG_Init = (state == BG_INIT);
    assign q_BG_Wait = (state == BG_WAIT);
    assign q_BG_Pick = (state == BG_PICK);
    assign q_BG_Fire = (state == BG_FIRE);

endmodule

// File: tb/tb_nexys_starship_break_gen.sv
// Randomized bench for nexys_starship_break_gen against a phase-level reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_nexys_starship_break_gen;

    localparam int SEED  = 'hACE1;
    localparam int BASE  = 40;
    localparam int JMASK = 'hF;

    localparam int M_IDLE   = 0;
    localparam int M_COUNT  = 1;
    localparam int M_CHOOSE = 2;
    localparam int M_FIRE   = 3;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       play;
    logic       go;
    logic [1:0] level;
    logic [3:0] broken;
    logic [3:0] break_req;
    logic [3:0] random_hex;
    logic [7:0] break_count;
    logic       q_init;
    logic       q_wait;
    logic       q_pick;
    logic       q_fire;

    int n_tests;
    int n_fail;
    int cyc;

    // Reference model state: register image of the LFSR plus game-level quantities.
    int m_lfsr;
    int m_mode;
    int m_left;
    int m_hex;
    int m_count;
    int m_req;

    nexys_starship_break_gen #(
        .LFSR_SEED     (16'hACE1),
        .BASE_INTERVAL (8'd40),
        .JITTER_MASK   (4'hF)
    ) dut (
        .Clk           (clk),
        .Reset         (rst),
        .timer_tick    (tick),
        .play_flag     (play),
        .gameover_ctrl (go),
        .level         (level),
        .broken        (broken),
        .break_req     (break_req),
        .random_hex    (random_hex),
        .break_count   (break_count),
        .q_BG_Init     (q_init),
        .q_BG_Wait     (q_wait),
        .q_BG_Pick     (q_pick),
        .q_BG_Fire     (q_fire)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lfsr_next(input int s);
        int fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s << 1) & 'hFFFF) | fb;
    endfunction

    function automatic int interval(input int cur, input int lvl);
        int l;
        l = (BASE >> lvl) + (((cur >> 8) & 'hF) & JMASK);
        return (l == 0) ? 1 : l;
    endfunction

    task automatic model_reset();
        m_lfsr  = SEED;
        m_mode  = M_IDLE;
        m_left  = 0;
        m_hex   = 1;
        m_count = 0;
        m_req   = 0;
    endtask

    // One clock of game behaviour, using the inputs present at the rising edge.
    task automatic model_step();
        int cur;
        int l;
        int t;
        int s;
        cur    = m_lfsr;
        m_lfsr = lfsr_next(cur);
        l      = interval(cur, int'(level));
        m_req  = 0;
        if (go) begin
            m_mode  = M_IDLE;
            m_count = 0;
        end else if (m_mode == M_IDLE) begin
            m_count = 0;
            if (play) begin
                m_left = l;
                m_mode = M_COUNT;
            end
        end else if (m_mode == M_COUNT) begin
            if (tick && m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = M_CHOOSE;
            end
        end else if (m_mode == M_CHOOSE) begin
            t = -1;
            for (int k = 0; k < 4; k++) begin
                s = ((cur & 3) + k) % 4;
                if (t < 0 && !broken[s]) t = s;
            end
            if (t < 0) begin
                m_left = l;
                m_mode = M_COUNT;
            end else begin
                m_req   = 1 << t;
                m_hex   = (((cur >> 4) & 'hF) == 0) ? 'hF : ((cur >> 4) & 'hF);
                m_count = (m_count < 255) ? m_count + 1 : 255;
                m_mode  = M_FIRE;
            end
        end else begin
            m_left = l;
            m_mode = M_COUNT;
        end
    endtask

    task automatic check_outputs();
        check("q_init", 32'(q_init), 32'(m_mode == M_IDLE));
        check("q_wait", 32'(q_wait), 32'(m_mode == M_COUNT));
        check("q_pick", 32'(q_pick), 32'(m_mode == M_CHOOSE));
        check("q_fire", 32'(q_fire), 32'(m_mode == M_FIRE));
        check("break_req", 32'(break_req), m_req);
        check("random_hex", 32'(random_hex), m_hex);
        check("break_count", 32'(break_count), m_count);
        check("req_onehot0", 32'($countones(break_req) <= 1), 32'd1);
        check("hex_nonzero", 32'(random_hex != 4'h0), 32'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    // Tick every cycle until the model reaches the requested phase; returns 1 on success.
    task automatic run_to(input int mode, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick = 1'b1;
            cycle();
            if (m_mode == mode) begin
                ok = 1'b1;
                break;
            end
        end
        tick = 1'b0;
    endtask

    initial begin
        bit   ok;
        bit   seen;
        int   t_at;
        int   fires;
        logic [3:0] saved_hex;

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst     = 1'b1;
        tick    = 1'b0;
        play    = 1'b0;
        go      = 1'b0;
        level   = 2'd0;
        broken  = 4'h0;
        model_reset();

        // Reset values.
        #1;
        check_outputs();
        check("rst_init", 32'(q_init), 32'd1);
        check("rst_hex", 32'(random_hex), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle until play, then WAIT on the next clock.
        repeat (3) cycle();
        play = 1'b1;
        cycle();
        check("t1_wait", 32'(q_wait), 32'd1);

        // Pulse latency: final tick presented at cycle t_at, pulse seen two cycles later.
        level = 2'd3;
        broken = 4'h0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick = 1'b1;
            t_at = cyc;
            cycle();
            if (m_mode == M_CHOOSE) begin
                ok = 1'b1;
                break;
            end
        end
        tick = 1'b0;
        check("t2_expiry_reached", 32'(ok), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (break_req != 4'h0) begin
                seen = 1'b1;
                check("t2_latency", cyc - t_at, 32'd2);
                break;
            end
        end
        check("t2_pulse_seen", 32'(seen), 32'd1);
        check("t2_count", 32'(break_count), 32'd1);

        // All broken: expiry yields no pulse and returns to WAIT.
        broken = 4'hF;
        run_to(M_CHOOSE, 100, ok);
        check("t3_choose_reached", 32'(ok), 32'd1);
        cycle();
        check("t3_no_pulse", 32'(break_req), 32'h0);
        check("t3_back_wait", 32'(q_wait), 32'd1);

        // Only BR healthy: always targets BR, whatever the start index.
        broken = 4'b1110;
        for (int r = 0; r < 6; r++) begin
            run_to(M_FIRE, 100, ok);
            check("t3_fire_reached", 32'(ok), 32'd1);
            check("t3_req_br", 32'(break_req), 32'h1);
        end

        // Game over on the edge that would start the pulse.
        broken = 4'h0;
        run_to(M_CHOOSE, 100, ok);
        check("t4_choose_reached", 32'(ok), 32'd1);
        saved_hex = random_hex;
        go = 1'b1;
        cycle();
        go = 1'b0;
        check("t4_req", 32'(break_req), 32'h0);
        check("t4_hex", 32'(random_hex), 32'(saved_hex));
        check("t4_init", 32'(q_init), 32'd1);
        check("t4_count", 32'(break_count), 32'd0);

        // Randomized play, including play_flag toggling and occasional game over.
        for (int i = 0; i < 3000; i++) begin
            tick   = ($urandom_range(0, 2) == 0);
            play   = ($urandom_range(0, 3) != 0);
            go     = ($urandom_range(0, 199) == 0);
            broken = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) broken = 4'hF;
            if ($urandom_range(0, 63) == 0) level = 2'($urandom_range(0, 3));
            cycle();
        end
        go = 1'b0;

        // Saturation: fresh game, 300 breaks with every subsystem healthy.
        go = 1'b1;
        cycle();
        go     = 1'b0;
        play   = 1'b1;
        broken = 4'h0;
        level  = 2'd3;
        fires  = 0;
        for (int i = 0; i < 20000 && fires < 300; i++) begin
            tick = 1'b1;
            cycle();
            if (break_req != 4'h0) fires++;
        end
        tick = 1'b0;
        check("t5_fires", fires, 32'd300);
        check("t5_saturated", 32'(break_count), 32'd255);

        // Asynchronous reset in the middle of WAIT.
        run_to(M_COUNT, 50, ok);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("t6_in_wait", 32'(q_wait), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("t6_init", 32'(q_init), 32'd1);
        check("t6_count", 32'(break_count), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        play = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick = 1'b1;
            cycle();
        end
        check("t6_still_init", 32'(q_init), 32'd1);
        play = 1'b1;
        run_to(M_FIRE, 100, ok);
        check("t6_fire_after_restart", 32'(ok), 32'd1);
        check("t6_first_break", 32'(break_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
